// File: rtl/reg_file8x16_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file8x16_if
// Brief    : Bus bundle for the 8x16 register file.
//            Carries the load vector, write data, read selects and read results.
// Revision : 1.0
// ============================================================================
interface reg_file8x16_if #(
    parameter int DW = 16
);
    logic [7:0]    ld;
    logic [DW-1:0] d_in;
    logic [2:0]    s_addr;
    logic [2:0]    r_addr;
    logic [DW-1:0] s_out;
    logic [DW-1:0] r_out;
    logic [7:0]    wr_cnt;
    logic          ld_err;

    modport master (
        output ld, d_in, s_addr, r_addr,
        input  s_out, r_out, wr_cnt, ld_err
    );

    modport slave (
        input  ld, d_in, s_addr, r_addr,
        output s_out, r_out, wr_cnt, ld_err
    );
endinterface
`default_nettype wire

// File: rtl/reg_file8x16.sv
`default_nettype none
// ============================================================================
// Module   : reg_file8x16
// Brief    : 8-entry x DW-bit register file with two registered read ports,
//            write-first bypass, a write counter and a sticky multi-hot flag.
// Revision : 1.0
// ============================================================================
module reg_file8x16 #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  wire logic        clk,
    input  wire logic        reset,
    reg_file8x16_if.slave    bus
);
    localparam logic [7:0] c_LD_ONE = 8'd1;
    localparam logic [7:0] c_CNT_INC = 8'd1;

    logic [DW-1:0] r_mem [NREG];
    logic [DW-1:0] r_s_out;
    logic [DW-1:0] r_r_out;
    logic [7:0]    r_wr_cnt;
    logic          r_ld_err;

    logic          w_any;
    logic          w_onehot;
    logic          w_valid;
    logic          w_illegal;
    logic [DW-1:0] w_s_data;
    logic [DW-1:0] w_r_data;

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    always_comb begin
        w_any     = (bus.ld != 8'h00);
        w_onehot  = ((bus.ld & (bus.ld - c_LD_ONE)) == 8'h00);
        w_valid   = w_any && w_onehot;
        w_illegal = w_any && !w_onehot;
    end

    // Write-first: a port reading the register being written sees d_in.
    always_comb begin
        w_s_data = r_mem[bus.s_addr];
        w_r_data = r_mem[bus.r_addr];
        if (w_valid && bus.ld[bus.s_addr]) begin
            w_s_data = bus.d_in;
        end
        if (w_valid && bus.ld[bus.r_addr]) begin
            w_r_data = bus.d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
            r_s_out  <= '0;
            r_r_out  <= '0;
            r_wr_cnt <= '0;
            r_ld_err <= 1'b0;
        end else begin
            r_s_out <= w_s_data;
            r_r_out <= w_r_data;
            if (w_valid) begin
                for (int i = 0; i < NREG; i++) begin
                    if (bus.ld[i]) begin
                        r_mem[i] <= bus.d_in;
                    end
                end
                r_wr_cnt <= r_wr_cnt + c_CNT_INC;
            end
            if (w_illegal) begin
                r_ld_err <= 1'b1;
            end
        end
    end

    assign bus.s_out  = r_s_out;
    assign bus.r_out  = r_r_out;
    assign bus.wr_cnt = r_wr_cnt;
    assign bus.ld_err = r_ld_err;
endmodule
`default_nettype wire

// File: tb/tb_reg_file8x16.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file8x16
// Brief    : Directed self-checking bench for reg_file8x16 with a scoreboard.
// Revision : 1.0
// ============================================================================
module tb_reg_file8x16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [15:0] s;
        logic [15:0] r;
        logic [7:0]  c;
        logic        e;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_mem [8];
    logic [7:0]  m_cnt;
    logic        m_err;

    reg_file8x16_if #(.DW(16)) bus ();

    reg_file8x16 #(.DW(16), .NREG(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one cycle, push the model's prediction, then compare after the edge.
    task automatic cycle(input logic rst_in, input logic [7:0] l, input logic [15:0] d,
                         input logic [2:0] sa, input logic [2:0] ra, input string tag);
        exp_t e;
        int   n;
        @(negedge clk);
        reset      = rst_in;
        bus.ld     = l;
        bus.d_in   = d;
        bus.s_addr = sa;
        bus.r_addr = ra;
        n = $countones(l);
        if (rst_in) begin
            for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
            m_cnt = 8'd0;
            m_err = 1'b0;
            e.s = 16'h0000;
            e.r = 16'h0000;
        end else begin
            e.s = (n == 1 && l[sa]) ? d : m_mem[sa];
            e.r = (n == 1 && l[ra]) ? d : m_mem[ra];
            if (n == 1) begin
                for (int i = 0; i < 8; i++) if (l[i]) m_mem[i] = d;
                m_cnt = m_cnt + 8'd1;
            end
            if (n > 1) m_err = 1'b1;
        end
        e.c   = m_cnt;
        e.e   = m_err;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".s_out"},  bus.s_out, e.s);
        chk({e.tag, ".r_out"},  bus.r_out, e.r);
        chk({e.tag, ".wr_cnt"}, {8'h00, bus.wr_cnt}, {8'h00, e.c});
        chk({e.tag, ".ld_err"}, {15'h0, bus.ld_err}, {15'h0, e.e});
    endtask

    initial begin
        bus.ld = 8'h00; bus.d_in = 16'h0000; bus.s_addr = 3'd0; bus.r_addr = 3'd0;
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
        m_cnt = 8'd0;
        m_err = 1'b0;

        // Reset and idle
        cycle(1'b1, 8'h00, 16'h0000, 3'd0, 3'd7, "rst");
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 16'h0000, 3'd0, 3'd7, "idle");
        chk("idle_const.s_out", bus.s_out, 16'h0000);
        chk("idle_const.wr_cnt", {8'h00, bus.wr_cnt}, 16'h0000);

        // Fill all registers, then read pairs
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 8'(1 << i), 16'(16'h1111 * (i + 1)), 3'd0, 3'd7, "fill");
        cycle(1'b0, 8'h00, 16'h0000, 3'd0, 3'd7, "rd07");
        chk("rd07_const.s_out", bus.s_out, 16'h1111);
        chk("rd07_const.r_out", bus.r_out, 16'h8888);
        chk("rd07_const.wr_cnt", {8'h00, bus.wr_cnt}, 16'd8);
        cycle(1'b0, 8'h00, 16'h0000, 3'd3, 3'd4, "rd34");
        chk("rd34_const.s_out", bus.s_out, 16'h4444);
        chk("rd34_const.r_out", bus.r_out, 16'h5555);
        cycle(1'b0, 8'h00, 16'h0000, 3'd6, 3'd6, "rd66");

        // Write-first bypass on S, plain read on R
        cycle(1'b0, 8'h08, 16'hBEEF, 3'd3, 3'd2, "byp");
        chk("byp_const.s_out", bus.s_out, 16'hBEEF);
        chk("byp_const.r_out", bus.r_out, 16'h3333);
        cycle(1'b0, 8'h00, 16'h0000, 3'd3, 3'd3, "byp_after");
        chk("byp_after_const.r_out", bus.r_out, 16'hBEEF);
        cycle(1'b0, 8'h40, 16'h0A0B, 3'd6, 3'd6, "byp_both");

        // Illegal multi-hot load: no write, no bypass, sticky flag
        cycle(1'b0, 8'h05, 16'hDEAD, 3'd0, 3'd2, "illegal");
        chk("illegal_const.s_out", bus.s_out, 16'h1111);
        chk("illegal_const.r_out", bus.r_out, 16'h3333);
        chk("illegal_const.ld_err", {15'h0, bus.ld_err}, 16'h0001);
        cycle(1'b0, 8'h00, 16'h0000, 3'd0, 3'd2, "illegal_rd");
        cycle(1'b0, 8'h02, 16'h7777, 3'd1, 3'd0, "post_illegal");
        chk("post_illegal_const.ld_err", {15'h0, bus.ld_err}, 16'h0001);
        cycle(1'b0, 8'hFF, 16'hFFFF, 3'd7, 3'd5, "illegal_all");

        // Counter wrap after 256 writes to reg5
        cycle(1'b1, 8'h00, 16'h0000, 3'd0, 3'd0, "rst2");
        for (int k = 0; k < 256; k++)
            cycle(1'b0, 8'h20, 16'(k * 3 + 1), 3'd5, 3'd0, "wrap");
        chk("wrap_const.wr_cnt", {8'h00, bus.wr_cnt}, 16'd0);
        cycle(1'b0, 8'h00, 16'h0000, 3'd5, 3'd5, "wrap_rd");
        chk("wrap_const.reg5", bus.s_out, 16'(255 * 3 + 1));

        // Reset beats a simultaneous write
        cycle(1'b0, 8'h80, 16'h1234, 3'd7, 3'd7, "pre_rst");
        cycle(1'b1, 8'h80, 16'hCAFE, 3'd7, 3'd7, "rst_wr");
        cycle(1'b0, 8'h00, 16'h0000, 3'd7, 3'd7, "rst_wr_rd");
        chk("rst_wr_const.reg7", bus.s_out, 16'h0000);
        chk("rst_wr_const.wr_cnt", {8'h00, bus.wr_cnt}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/reg_file8x16.md
Name: reg_file8x16

Overview:
- 8-entry x 16-bit register file. It sits directly downstream of the 3-to-8 write decoder in the Project 4 datapath.
- The decoder's 8-bit one-hot output drives this block's load vector. The qualified step/write strobe is already folded into that vector.
- Two independent read ports, S and R, feed the ALU operand buses. Both are registered.
- A sticky error flag catches malformed (multi-hot) load vectors.

Parameters:
- DW, 16, data width of each register and of d_in/s_out/r_out.
- NREG, 8, number of registers. Fixed at 8, because the load vector is the 8-bit decoder output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ld  input  8  one-hot load vector from the decoder; bit i writes register i.
- d_in  input  DW  write data.
- s_addr  input  3  S read-port register select.
- r_addr  input  3  R read-port register select.
- s_out  output  DW  registered S read data.
- r_out  output  DW  registered R read data.
- wr_cnt  output  8  count of accepted writes; wraps at 255 -> 0.
- ld_err  output  1  sticky flag; set when ld has more than one bit high.

Behaviour:
- Reset (sampled on the clk edge with reset=1):
  - All 8 registers go to 16'h0000.
  - s_out=0, r_out=0, wr_cnt=0, ld_err=0.
  - Reset has priority over any write or read in the same cycle; a write presented during reset is discarded.
- Load classification, decided combinationally each cycle:
  - ld==8'h00: idle.
  - Exactly one bit set: valid write.
  - Two or more bits set: illegal.
- Valid write: at the clock edge, reg[i] <= d_in, where i is the set bit; wr_cnt <= wr_cnt+1, modulo 256.
- Illegal ld:
  - No register is modified and wr_cnt is unchanged.
  - ld_err <= 1 and stays 1 until reset.
- Read ports:
  - Each edge: s_out <= reg[s_addr], r_out <= reg[r_addr].
  - Latency: 1 cycle from address to data.
  - Both ports are fully independent; s_addr==r_addr is legal and gives identical data.
- Read/write collision (write-first bypass): if a valid write targets the register addressed by s_addr or r_addr in the same cycle, that port captures d_in, not the old contents. Either port, or both, may bypass.
- Illegal-ld cycles never bypass; reads return the stored contents.
- Inputs are not registered. ld, d_in and the addresses are sampled directly at the edge, since the decoder output is combinational from step/write/y.
- No X propagation: all storage is reset, so outputs are defined from the first post-reset cycle.
- Registers hold their value indefinitely when ld==0; there is no clear other than reset.

Test Plan:
1. Reset, then hold ld=0 for 3 cycles with s_addr=0, r_addr=7 -> s_out=0, r_out=0, wr_cnt=0, ld_err=0 throughout.
2. Write d_in=16'h1111*(i+1) with ld=1<<i for i=0..7, then read pairs (0,7),(3,4) -> s_out=16'h1111/r_out=16'h8888, then 16'h4444/16'h5555 one cycle after each address; wr_cnt=8.
3. Bypass: reg3 holds 16'h4444; apply ld=8'h08, d_in=16'hBEEF, s_addr=3, r_addr=2 in the same cycle -> next cycle s_out=16'hBEEF, r_out=16'h3333; the cycle after, reg3 reads 16'hBEEF.
4. Illegal ld=8'h05 with d_in=16'hDEAD -> reg0=16'h1111 and reg2=16'h3333 unchanged, wr_cnt unchanged, ld_err=1; a following legal write still succeeds and ld_err stays 1.
5. Perform 256 legal writes to reg5 -> wr_cnt wraps to 0; reg5 holds the last data written.
6. Assert reset in the same cycle as ld=8'h80, d_in=16'hCAFE -> reg7=0, s_out=r_out=0, wr_cnt=0, ld_err=0 on the next cycle; no write retained.
